clarvi_serial_lsu: RTL and testbench
====================================

Name: clarvi_serial_lsu

Overview:
- Parametrised lane-serial load/store unit for the narrow-datapath Clarvi core.
- Accepts rs1, rs2 and immediate one LANE-wide slice per cycle, LSB slice first, and accumulates the XLEN-bit effective address with carry propagated between slices.
- Sequences 1..NPARTS lane-wide memory accesses, with optional misalignment and range faults and memory wait states.
- Streams the load result back LSB-first with sign or zero extension. Sits between the execute stage and the data memory port.

Parameters:
- XLEN, 64, architectural register/address width; must be a multiple of LANE.
- LANE, 8, datapath slice width in bits (8, 16 or 32); memory is addressed in LANE-sized units.
- DATA_ADDR_WIDTH, 14, implemented memory address width in lane units.
- MISALIGNED_OK, 1, 1 = misaligned accesses permitted; 0 = fault when base address is not a multiple of the access count.
- Derived: NPARTS = XLEN/LANE; access count AC = max(1, 8·2^width / LANE), capped at NPARTS.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  operand slice valid
- op_ready  out  1  unit accepts operand slice
- op_first  in  1  marks slice 0; cmd fields sampled only on this slice
- op_store  in  1  1 = store, 0 = load (cmd)
- op_width  in  2  0=B, 1=H, 2=W, 3=D (cmd)
- op_unsigned  in  1  zero-extend load (cmd)
- op_rs1  in  LANE  rs1 slice
- op_rs2  in  LANE  store-data slice
- op_imm  in  LANE  immediate slice, already sign-extended by the sender
- mem_address  out  DATA_ADDR_WIDTH  lane-unit address
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_wdata  out  LANE  write data
- mem_wait  in  1  memory not accepting; hold request
- mem_rdata  in  LANE  read data, valid exactly 1 cycle after an accepted read
- res_valid  out  1  result slice valid
- res_ready  in  1  consumer accepts result slice
- res_data  out  LANE  load result slice; 0 for stores and faults
- res_last  out  1  final result slice
- res_fault  out  1  address/alignment fault, valid with res_last
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. op_ready=1; all other outputs 0, including mem_read, mem_write, res_valid and busy. All counters cleared.
- Reset mid-operation aborts the operation. The next cycle has no memory strobe; an in-flight read response is discarded.
- States: IDLE, ADDR, CHECK, ACCESS, DRAIN, RESP.
- IDLE:
  - op_ready=1.
  - Slice accepted with op_first=1: latch cmd, compute slice 0 = rs1+imm (LANE+1 bits, carry saved), buffer rs2 slice, go to ADDR with part=1.
  - op_valid without op_first is ignored.
  - NPARTS=1 goes directly to CHECK.
- ADDR:
  - op_ready=1. Each accepted slice k computes addr[k·LANE +: LANE] = rs1+imm+carry and buffers rs2 slice k.
  - After slice NPARTS-1, go to CHECK. op_first asserted in ADDR is ignored (treated as a continuation).
- CHECK (1 cycle, op_ready=0):
  - Fault if addr bits ≥ DATA_ADDR_WIDTH are nonzero, or if MISALIGNED_OK=0 and addr mod AC != 0.
  - Fault: go to RESP with a single beat, res_fault=1, no memory strobe. Otherwise go to ACCESS with idx=0.
- ACCESS:
  - mem_address = addr[DATA_ADDR_WIDTH-1:0] + idx, wrapping modulo 2^DATA_ADDR_WIDTH.
  - mem_read = !op_store; mem_write = op_store; mem_wdata = store slice idx.
  - A request is accepted on a cycle where the strobe is high and mem_wait=0; idx then increments. While mem_wait=1, address, strobe and data are held stable.
  - Reads are pipelined: the response for access i is captured into rbuf[i] the cycle after acceptance, while access i+1 may issue.
  - After access AC-1 is accepted: a store goes to RESP; a load goes to DRAIN for 1 cycle to capture the last response, then RESP.
- RESP:
  - Loads emit NPARTS beats. Beat j has res_data = rbuf[j] for j < AC; otherwise the extension fill, all-ones if (!op_unsigned && rbuf[AC-1][LANE-1]), else 0.
  - Stores and faults emit one beat.
  - A beat advances on res_valid && res_ready; res_last is high on the final beat. After it is accepted, return to IDLE.
  - op_ready=1 is only asserted in IDLE/ADDR, so no new operation overlaps RESP.
- Width D with XLEN=32 is treated as W.
- Latency (load D, LANE=8, no wait, res_ready=1): 8 operand cycles, 1 CHECK, 8 ACCESS, 1 DRAIN, 8 RESP. The first res beat appears 18 cycles after the first operand slice is accepted.

Test Plan:
- LB, rs1=0x..00_00FF, imm=1, no wait -> carry into slice 1, address 0x100, one read. rdata=0x80 -> res beats 0x80, then 7×0xFF; res_fault=0.
- LHU, rs1=0x10, imm=-1 (0xFF..FF) -> address 0x0F; reads at 0x0F and 0x10 returning 0xAB, 0xCD -> beats 0xAB, 0xCD, 6×0x00.
- SD, addr=0x20, rs2=0x0807060504030201, mem_wait high for 2 cycles on access 3 -> writes 0x01..0x08 to 0x20..0x27, in order, each exactly once; access 3 held stable during the wait; single res beat with res_last=1.
- LW, rs1 bit 40 set -> res_fault=1 on a single beat, mem_read never asserted.
- MISALIGNED_OK=0, LW at 0x21 -> fault. MISALIGNED_OK=1, same address -> reads 0x21..0x24.
- Reset asserted during ACCESS of an SD after 3 writes -> no further mem_write; busy=0 and op_ready=1 the cycle after reset deasserts. A new LB then completes normally.

Source files
------------

// File: rtl/clarvi_serial_lsu.sv
// Lane-serial load/store unit: accumulates the effective address one LANE slice per
// cycle, sequences lane-wide memory accesses and streams the load result LSB-first.
module clarvi_serial_lsu #(
    parameter int unsigned XLEN            = 64,
    parameter int unsigned LANE            = 8,
    parameter int unsigned DATA_ADDR_WIDTH = 14,
    parameter bit          MISALIGNED_OK   = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic                       op_first,
    input  logic                       op_store,
    input  logic [1:0]                 op_width,
    input  logic                       op_unsigned,
    input  logic [LANE-1:0]            op_rs1,
    input  logic [LANE-1:0]            op_rs2,
    input  logic [LANE-1:0]            op_imm,
    output logic [DATA_ADDR_WIDTH-1:0] mem_address,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [LANE-1:0]            mem_wdata,
    input  logic                       mem_wait,
    input  logic [LANE-1:0]            mem_rdata,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [LANE-1:0]            res_data,
    output logic                       res_last,
    output logic                       res_fault,
    output logic                       busy
);
    localparam int unsigned NPARTS = XLEN / LANE;
    localparam int unsigned CW     = $clog2(NPARTS + 1);
    localparam int unsigned IW     = (NPARTS > 1) ? $clog2(NPARTS) : 1;
    localparam int unsigned SW     = LANE + 1;

    typedef enum logic [2:0] {IDLE, ADDR, CHECK, ACCESS, DRAIN, RESP} state_t;

    state_t                        state;
    logic                          st_store;
    logic                          st_unsigned;
    logic [CW-1:0]                 ac;
    logic                          carry;
    logic [NPARTS-1:0][LANE-1:0]   addr_q;
    logic [NPARTS-1:0][LANE-1:0]   sbuf;
    logic [NPARTS-1:0][LANE-1:0]   rbuf;
    logic [CW-1:0]                 part;
    logic [CW-1:0]                 idx;
    logic [CW-1:0]                 beat;
    logic                          rd_pend;
    logic [IW-1:0]                 rd_idx;

    // Number of lane accesses for a B/H/W/D access, at least one, at most a full register.
    function automatic logic [CW-1:0] access_count(input logic [1:0] w);
        int unsigned n;
        n = (32'd8 << w) / LANE;
        if (n < 1) n = 1;
        if (n > NPARTS) n = NPARTS;
        return CW'(n);
    endfunction

    logic            carry_in;
    logic [SW-1:0]   slice_sum;
    logic [XLEN-1:0] addr_flat;
    logic            hi_fault;
    logic            mis_fault;

    assign carry_in  = (state == IDLE) ? 1'b0 : carry;
    assign slice_sum = SW'(op_rs1) + SW'(op_imm) + SW'(carry_in);
    assign addr_flat = addr_q;
    assign hi_fault  = |(addr_flat >> DATA_ADDR_WIDTH);
    assign mis_fault = !MISALIGNED_OK && (|(addr_flat[CW-1:0] & (ac - CW'(1))));

    // Read buffer as it will look once any in-flight response lands this cycle.
    logic [NPARTS-1:0][LANE-1:0] rbuf_view;
    logic [CW-1:0]               nbeat;
    logic [LANE-1:0]             fill;
    logic [LANE-1:0]             nbeat_data;
    logic                        nbeat_last;

    always_comb begin
        rbuf_view = rbuf;
        if (rd_pend) rbuf_view[rd_idx] = mem_rdata;
        nbeat      = (state == RESP) ? beat + CW'(1) : '0;
        fill       = (!st_unsigned && rbuf_view[IW'(ac - CW'(1))][LANE-1]) ? '1 : '0;
        nbeat_data = (nbeat < ac) ? rbuf_view[IW'(nbeat)] : fill;
        nbeat_last = (nbeat == CW'(NPARTS - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            op_ready    <= 1'b1;
            busy        <= 1'b0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_wdata   <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_last    <= 1'b0;
            res_fault   <= 1'b0;
            st_store    <= 1'b0;
            st_unsigned <= 1'b0;
            ac          <= '0;
            carry       <= 1'b0;
            addr_q      <= '0;
            sbuf        <= '0;
            rbuf        <= '0;
            part        <= '0;
            idx         <= '0;
            beat        <= '0;
            rd_pend     <= 1'b0;
            rd_idx      <= '0;
        end else begin
            rd_pend <= 1'b0;
            if (rd_pend) rbuf[rd_idx] <= mem_rdata;

            case (state)
                IDLE: begin
                    if (op_valid && op_first) begin
                        st_store    <= op_store;
                        st_unsigned <= op_unsigned;
                        ac          <= access_count(op_width);
                        addr_q[0]   <= slice_sum[LANE-1:0];
                        carry       <= slice_sum[LANE];
                        sbuf[0]     <= op_rs2;
                        part        <= CW'(1);
                        busy        <= 1'b1;
                        if (NPARTS == 1) begin
                            state    <= CHECK;
                            op_ready <= 1'b0;
                        end else begin
                            state <= ADDR;
                        end
                    end
                end

                // op_first here is just another continuation slice
                ADDR: begin
                    if (op_valid) begin
                        addr_q[IW'(part)] <= slice_sum[LANE-1:0];
                        carry             <= slice_sum[LANE];
                        sbuf[IW'(part)]   <= op_rs2;
                        part              <= part + CW'(1);
                        if (part == CW'(NPARTS - 1)) begin
                            state    <= CHECK;
                            op_ready <= 1'b0;
                        end
                    end
                end

                CHECK: begin
                    part <= '0;
                    idx  <= '0;
                    beat <= '0;
                    if (hi_fault || mis_fault) begin
                        state     <= RESP;
                        res_valid <= 1'b1;
                        res_last  <= 1'b1;
                        res_fault <= 1'b1;
                        res_data  <= '0;
                    end else begin
                        state       <= ACCESS;
                        mem_address <= addr_flat[DATA_ADDR_WIDTH-1:0];
                        mem_read    <= !st_store;
                        mem_write   <= st_store;
                        mem_wdata   <= st_store ? sbuf[0] : '0;
                    end
                end

                // Request held stable until the memory drops mem_wait
                ACCESS: begin
                    if (!mem_wait) begin
                        if (mem_read) begin
                            rd_pend <= 1'b1;
                            rd_idx  <= IW'(idx);
                        end
                        if (idx == ac - CW'(1)) begin
                            mem_read  <= 1'b0;
                            mem_write <= 1'b0;
                            mem_wdata <= '0;
                            if (st_store) begin
                                state     <= RESP;
                                res_valid <= 1'b1;
                                res_last  <= 1'b1;
                                res_fault <= 1'b0;
                                res_data  <= '0;
                            end else begin
                                state <= DRAIN;
                            end
                        end else begin
                            idx         <= idx + CW'(1);
                            mem_address <= mem_address + DATA_ADDR_WIDTH'(1);
                            mem_wdata   <= st_store ? sbuf[IW'(idx + CW'(1))] : '0;
                        end
                    end
                end

                DRAIN: begin
                    state     <= RESP;
                    beat      <= '0;
                    res_valid <= 1'b1;
                    res_data  <= nbeat_data;
                    res_last  <= nbeat_last;
                    res_fault <= 1'b0;
                end

                RESP: begin
                    if (res_ready) begin
                        if (res_last) begin
                            state     <= IDLE;
                            res_valid <= 1'b0;
                            res_last  <= 1'b0;
                            res_fault <= 1'b0;
                            res_data  <= '0;
                            op_ready  <= 1'b1;
                            busy      <= 1'b0;
                            beat      <= '0;
                        end else begin
                            beat     <= nbeat;
                            res_data <= nbeat_data;
                            res_last <= nbeat_last;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clarvi_serial_lsu.sv
// Directed scoreboard bench: a misaligned-OK unit on a memory model with wait states,
// plus an aligned-only unit used for the alignment-fault cases.
module tb_clarvi_serial_lsu;
    localparam int unsigned LANE = 8;
    localparam int unsigned DAW  = 14;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            op_valid = 1'b0, op_valid_al = 1'b0, op_first = 1'b0;
    logic            op_store = 1'b0, op_unsigned = 1'b0;
    logic [1:0]      op_width = 2'd0;
    logic [LANE-1:0] op_rs1 = '0, op_rs2 = '0, op_imm = '0;
    logic            res_ready = 1'b1;
    logic            bp = 1'b0;

    logic            op_ready, mem_read, mem_write, mem_wait, res_valid, res_last, res_fault, busy;
    logic [DAW-1:0]  mem_address;
    logic [LANE-1:0] mem_wdata, mem_rdata, res_data;

    logic            op_ready_al, mem_read_al, mem_write_al, res_valid_al, res_last_al, res_fault_al, busy_al;
    logic [DAW-1:0]  mem_address_al;
    logic [LANE-1:0] mem_wdata_al, mem_rdata_al, res_data_al;

    clarvi_serial_lsu #(.XLEN(64), .LANE(8), .DATA_ADDR_WIDTH(14), .MISALIGNED_OK(1'b1)) dut (
        .clock(clock), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_first(op_first), .op_store(op_store),
        .op_width(op_width), .op_unsigned(op_unsigned), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_imm(op_imm),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_wait(mem_wait), .mem_rdata(mem_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .res_fault(res_fault), .busy(busy)
    );

    clarvi_serial_lsu #(.XLEN(64), .LANE(8), .DATA_ADDR_WIDTH(14), .MISALIGNED_OK(1'b0)) dut_al (
        .clock(clock), .reset(reset),
        .op_valid(op_valid_al), .op_ready(op_ready_al), .op_first(op_first), .op_store(op_store),
        .op_width(op_width), .op_unsigned(op_unsigned), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_imm(op_imm),
        .mem_address(mem_address_al), .mem_read(mem_read_al), .mem_write(mem_write_al), .mem_wdata(mem_wdata_al),
        .mem_wait(1'b0), .mem_rdata(mem_rdata_al),
        .res_valid(res_valid_al), .res_ready(1'b1), .res_data(res_data_al), .res_last(res_last_al),
        .res_fault(res_fault_al), .busy(busy_al)
    );

    initial forever #5 clock = ~clock;

    // Memory model: one-cycle read latency, wait states on a chosen address
    logic [7:0]     mem [0:(1<<DAW)-1];
    bit             loaded = 1'b0;
    int             wait_done = 0;
    int             wait_total = 0;
    logic [DAW-1:0] wait_addr = '0;
    int             cyc = 0;

    assign mem_wait = (mem_read || mem_write) && (mem_address == wait_addr) && (wait_done < wait_total);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!loaded) begin
            for (int a = 0; a < (1 << DAW); a++) mem[a] <= 8'h00;
            mem[14'h100] <= 8'h80;
            mem[14'h00F] <= 8'hAB;
            mem[14'h010] <= 8'hCD;
            mem[14'h030] <= 8'h11;
            mem[14'h031] <= 8'h22;
            mem[14'h032] <= 8'h33;
            mem[14'h033] <= 8'hF4;
            loaded <= 1'b1;
        end else if (mem_write && !mem_wait && !reset) begin
            mem[mem_address] <= mem_wdata;
        end
        if (mem_wait) wait_done <= wait_done + 1;
        mem_rdata    <= (mem_read && !mem_wait && !reset) ? mem[mem_address] : 8'hEE;
        mem_rdata_al <= (mem_read_al && !reset) ? mem[mem_address_al] : 8'hEE;
    end

    initial forever begin
        @(posedge clock);
        #1;
        res_ready = bp ? ~res_ready : 1'b1;
    end

    // Scoreboard queues: {last, fault, data} beats, read addresses, {address, data} writes
    logic [9:0]       exp_res[$];
    logic [9:0]       exp_res_al[$];
    logic [DAW-1:0]   exp_rd[$];
    logic [DAW-1:0]   exp_rd_al[$];
    logic [DAW+7:0]   exp_wr[$];
    int               checks = 0;
    int               failures = 0;
    int               wr_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h expected nothing", name, act);
    endtask

    // Monitor: pops expectations whenever the DUT presents a transaction
    initial begin
        logic           hold_p;
        logic [DAW+9:0] hold_v;
        hold_p = 1'b0;
        hold_v = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                hold_p = 1'b0;
            end else begin
                if (res_valid && res_ready) begin
                    if (exp_res.size() == 0) unexpected("res_beat", {res_last, res_fault, res_data});
                    else chk("res_beat", {res_last, res_fault, res_data}, exp_res.pop_front());
                end
                if (res_valid_al) begin
                    if (exp_res_al.size() == 0) unexpected("res_beat_al", {res_last_al, res_fault_al, res_data_al});
                    else chk("res_beat_al", {res_last_al, res_fault_al, res_data_al}, exp_res_al.pop_front());
                end
                if (hold_p)
                    chk("wait_hold", {mem_read, mem_write, mem_address, mem_wdata}, hold_v);
                hold_p = mem_wait;
                hold_v = {mem_read, mem_write, mem_address, mem_wdata};
                if (mem_read && !mem_wait) begin
                    if (exp_rd.size() == 0) unexpected("rd_addr", mem_address);
                    else chk("rd_addr", mem_address, exp_rd.pop_front());
                end
                if (mem_write && !mem_wait) begin
                    wr_cnt++;
                    if (exp_wr.size() == 0) unexpected("wr", {mem_address, mem_wdata});
                    else chk("wr", {mem_address, mem_wdata}, exp_wr.pop_front());
                end
                if (mem_read_al) begin
                    if (exp_rd_al.size() == 0) unexpected("rd_addr_al", mem_address_al);
                    else chk("rd_addr_al", mem_address_al, exp_rd_al.pop_front());
                end
                if (mem_write_al) unexpected("wr_al", {mem_address_al, mem_wdata_al});
            end
        end
    end

    task automatic exp_beats(input bit al, input logic [63:0] v, input int n, input bit fault);
        for (int j = 0; j < n; j++) begin
            logic [9:0] e;
            e = {(j == n - 1), fault, v[j*8 +: 8]};
            if (al) exp_res_al.push_back(e);
            else exp_res.push_back(e);
        end
    endtask

    task automatic exp_reads(input bit al, input logic [DAW-1:0] base, input int n);
        for (int j = 0; j < n; j++) begin
            if (al) exp_rd_al.push_back(base + DAW'(j));
            else exp_rd.push_back(base + DAW'(j));
        end
    endtask

    int t0 = 0;

    task automatic send_op(input bit al, input bit store, input logic [1:0] w, input bit uns,
                           input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm);
        chk(al ? "op_ready_idle_al" : "op_ready_idle", al ? op_ready_al : op_ready, 1);
        for (int k = 0; k < 8; k++) begin
            if (al) op_valid_al = 1'b1;
            else op_valid = 1'b1;
            op_first    = (k == 0);
            op_store    = store;
            op_width    = w;
            op_unsigned = uns;
            op_rs1      = rs1[k*8 +: 8];
            op_rs2      = rs2[k*8 +: 8];
            op_imm      = imm[k*8 +: 8];
            if (k == 0) t0 = cyc;
            @(posedge clock);
            #1;
        end
        op_valid    = 1'b0;
        op_valid_al = 1'b0;
        op_first    = 1'b0;
    endtask

    task automatic wait_idle(input bit al, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (((al ? exp_res_al.size() : exp_res.size()) != 0 || (al ? busy_al : busy)) && n < 300);
        if (n >= 300) unexpected({name, "_timeout"}, n);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        int wr_base;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_op_ready", op_ready, 1);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_res", {res_valid, res_last, res_fault, res_data}, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // LB with carry into slice 1: address 0x100, sign-extended 0x80
        exp_reads(0, 14'h100, 1);
        exp_beats(0, 64'hFFFF_FFFF_FFFF_FF80, 8, 0);
        send_op(0, 0, 2'd0, 0, 64'h0000_0000_0000_00FF, 64'h0, 64'h1);
        wait_idle(0, "lb");

        // LHU at 0x10 + (-1) with result backpressure
        bp = 1'b1;
        exp_reads(0, 14'h00F, 2);
        exp_beats(0, 64'h0000_0000_0000_CDAB, 8, 0);
        send_op(0, 0, 2'd1, 1, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle(0, "lhu");
        bp = 1'b0;

        // SD at 0x20 with two wait states on access 3
        wait_addr  = 14'h023;
        wait_total = 2;
        for (int i = 0; i < 8; i++) exp_wr.push_back({14'h020 + DAW'(i), 8'(i + 1)});
        exp_beats(0, 64'h0, 1, 0);
        send_op(0, 1, 2'd3, 0, 64'h20, 64'h0807_0605_0403_0201, 64'h0);
        wait_idle(0, "sd");

        // LW with address bit 40 set: range fault, no read
        exp_beats(0, 64'h0, 1, 1);
        send_op(0, 0, 2'd2, 0, 64'h0000_0100_0000_0000, 64'h0, 64'h0);
        wait_idle(0, "lw_range");

        // Misaligned LW at 0x21 permitted
        exp_reads(0, 14'h021, 4);
        exp_beats(0, 64'h0000_0000_0504_0302, 8, 0);
        send_op(0, 0, 2'd2, 0, 64'h21, 64'h0, 64'h0);
        wait_idle(0, "lw_mis");

        // LW at 0x40 - 16 = 0x30, negative word sign-extends
        exp_reads(0, 14'h030, 4);
        exp_beats(0, 64'hFFFF_FFFF_F433_2211, 8, 0);
        send_op(0, 0, 2'd2, 0, 64'h40, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0);
        wait_idle(0, "lw_neg");

        // Aligned-only unit: LW at 0x21 faults, LH at 0x32 reads 0x32/0x33
        exp_beats(1, 64'h0, 1, 1);
        send_op(1, 0, 2'd2, 0, 64'h21, 64'h0, 64'h0);
        wait_idle(1, "al_fault");
        exp_reads(1, 14'h032, 2);
        exp_beats(1, 64'hFFFF_FFFF_FFFF_F433, 8, 0);
        send_op(1, 0, 2'd1, 0, 64'h32, 64'h0, 64'h0);
        wait_idle(1, "al_lh");

        // LD latency: first result beat 18 cycles after slice 0
        exp_reads(0, 14'h020, 8);
        exp_beats(0, 64'h0807_0605_0403_0201, 8, 0);
        send_op(0, 0, 2'd3, 0, 64'h20, 64'h0, 64'h0);
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("ld_latency", 64'(cyc - t0), 18);
        wait_idle(0, "ld");

        // Reset during SD access after three writes
        wr_base = wr_cnt;
        exp_wr.push_back({14'h040, 8'hAA});
        exp_wr.push_back({14'h041, 8'hBB});
        exp_wr.push_back({14'h042, 8'hCC});
        send_op(0, 1, 2'd3, 0, 64'h40, 64'h1111_1111_11CC_BBAA, 64'h0);
        n = 0;
        while (wr_cnt < wr_base + 3 && n < 50) begin
            @(posedge clock);
            n++;
        end
        if (n >= 50) unexpected("sd_reset_timeout", n);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_busy_ready", {busy, op_ready}, 2'b01);
        chk("post_rst_strobes", {mem_read, mem_write, res_valid}, 0);
        repeat (4) @(posedge clock);
        #1;

        // New LB after the abort sees the byte written before reset
        exp_reads(0, 14'h041, 1);
        exp_beats(0, 64'hFFFF_FFFF_FFFF_FFBB, 8, 0);
        send_op(0, 0, 2'd0, 0, 64'h41, 64'h0, 64'h0);
        wait_idle(0, "lb_after_rst");

        repeat (3) @(posedge clock);
        chk("wr_left", 64'(exp_wr.size()), 0);
        chk("rd_left", 64'(exp_rd.size() + exp_rd_al.size()), 0);
        chk("res_left", 64'(exp_res.size() + exp_res_al.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
